datapath_sequencer: RTL and testbench
=====================================

# datapath_sequencer

Instruction sequencer for the 4-register, 32-bit load/add datapath. Accepts one 32-bit instruction at a time over a valid/ready handshake and decodes it. Drives the datapath's register-select, mux-select and write-enable controls, and runs a request/acknowledge handshake with memory for loads and stores. Sits between an instruction source (test host or fetch unit) and the datapath; memory address and write data come from the datapath's Address_out and Data_out.

## Interface
- TIMEOUT, 16: cycles to wait for mem_ack before abort (≥1)
- CNT_W, 16: width of retired-instruction counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- instr  in  32  instruction word
- instr_valid  in  1  instr is valid
- instr_ready  out  1  sequencer can accept; high exactly in IDLE
- load_enable  out  1  register-file write enable
- dest_select, A_select, B_select  out  2 each  register selects
- mb_select  out  1  1 = constant_in to adder B input, 0 = register B
- md_select  out  1  1 = Data_in written back, 0 = adder result
- constant_in  out  32  zero-extended immediate
- mem_rd, mem_wr  out  1 each  memory request (address = datapath Address_out)
- mem_ack  in  1  memory completes request this cycle
- busy  out  1  state ≠ IDLE
- err  out  1  sticky error flag
- retired  out  CNT_W  count of completed instructions

## Operation
- Instruction fields:
  - op = instr[31:29]
  - rd = [28:27]
  - ra = [26:25]
  - rb = [24:23]
  - imm = [22:0], zero-extended to 32
- Opcodes:
  - 000 NOP
  - 001 ADD rd=ra+rb
  - 010 ADDI rd=ra+imm
  - 011 LOAD rd=Mem[ra]
  - 100 STORE Mem[ra]=rb
  - 101 STOREI Mem[ra]=imm
  - 110/111 illegal
- Accept on instr_valid && instr_ready; instr latched into IR, err cleared on accept.
- States: IDLE, EXEC, MEM_RD, MEM_WR.
  - IDLE→EXEC for NOP/ADD/ADDI/illegal; →MEM_RD for LOAD; →MEM_WR for STORE/STOREI.
  - EXEC: one cycle.
    - ADD/ADDI: load_enable=1, md_select=0.
    - ADDI: mb_select=1.
    - Illegal: no write, err set.
    - →IDLE.
  - MEM_RD: mem_rd=1, A_select=ra.
    - On mem_ack: load_enable=1, md_select=1, dest_select=rd in that same cycle (Mealy on mem_ack) →IDLE.
  - MEM_WR: mem_wr=1, A_select=ra.
    - B_select=rb, mb_select=0 (STORE); or mb_select=1 (STOREI).
    - On mem_ack →IDLE. No register write.
- Timeout:
  - Wait counter loads 0 on entering MEM_RD/MEM_WR and increments per cycle without mem_ack.
  - When it reaches TIMEOUT-1 without ack: err=1, no write, →IDLE. The instruction does not retire.
- Control outputs are decoded from state and IR only. Exceptions: load_enable and md_select in MEM_RD also depend on mem_ack.
- Selects carry IR fields in every non-IDLE state. They are 0 in IDLE.
- retired increments by 1 when NOP, ADD, ADDI, LOAD, STORE or STOREI completes. Illegal and timed-out instructions do not count. The counter wraps modulo 2^CNT_W.
- mem_ack outside MEM_RD/MEM_WR is ignored.

## Timing
- Reset (asynchronous) forces:
  - state=IDLE
  - IR=0, err=0, retired=0, wait counter=0
  - all control outputs 0, instr_ready=1
- ADD/ADDI/NOP: accept at edge N, write at edge N+1, instr_ready high again after N+1. Throughput is 1 instruction per 2 cycles.
- LOAD/STORE with ack k cycles after entering the memory state (k≥0): completion at edge N+1+k.
- mem_rd/mem_wr are held high continuously until the ack cycle or the timeout cycle inclusive. They drop the cycle after.
- instr_valid while busy: not accepted. The source must hold instr stable until the handshake.
- Reset mid-operation aborts immediately:
  - no further write or request
  - outstanding memory transaction is dropped

## Test plan
- Reset, then ADDI r1 imm=5 (instr=0x4A000005) → one cycle with load_enable=1, dest_select=1, mb_select=1, constant_in=5; retired=1; instr_ready back high 2 cycles after accept.
- ADD r2=r1+r1 following it → A_select=B_select=1, mb_select=0, dest_select=2; datapath r2=10; retired=2.
- LOAD r3 from [r2] with mem_ack after 3 cycles, Data_in=0xDEADBEEF → mem_rd high 4 cycles; load_enable=md_select=1 only in the ack cycle; r3=0xDEADBEEF.
- STOREI [r2]=0x7 with mem_ack never asserted, TIMEOUT=4 → mem_wr high 4 cycles, then err=1, retired unchanged. The next accepted NOP clears err.
- Illegal opcode 111 → no load_enable, err=1, retired unchanged. Assert reset during MEM_RD → mem_rd=0 and all outputs at reset values immediately (asynchronous).
- Counter wrap: CNT_W=2, 5 NOPs → retired=1.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Purpose: decodes one 32-bit instruction at a time into register-file / adder-mux controls and memory requests.
// Latency: ALU ops and NOP complete one cycle after accept; loads/stores complete on mem_ack or abort after TIMEOUT cycles.
// Backpressure: instr_ready is high only in IDLE; a held instr_valid waits there until the current instruction finishes.
module datapath_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             load_enable,
  output logic [1:0]       dest_select,
  output logic [1:0]       A_select,
  output logic [1:0]       B_select,
  output logic             mb_select,
  output logic             md_select,
  output logic [31:0]      constant_in,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic             mem_ack,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_ADDI   = 3'b010;
  localparam logic [2:0] OP_LOAD   = 3'b011;
  localparam logic [2:0] OP_STORE  = 3'b100;
  localparam logic [2:0] OP_STOREI = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_MEM_RD = 2'd2,
    S_MEM_WR = 2'd3
  } state_t;

  state_t            state;
  logic [31:0]       ir;
  logic [WAIT_W-1:0] wait_cnt;

  logic [2:0]  ir_op;
  logic [1:0]  ir_rd;
  logic [1:0]  ir_ra;
  logic [1:0]  ir_rb;
  logic [22:0] ir_imm;
  logic        ir_legal;
  logic        accept;

  assign ir_op    = ir[31:29];
  assign ir_rd    = ir[28:27];
  assign ir_ra    = ir[26:25];
  assign ir_rb    = ir[24:23];
  assign ir_imm   = ir[22:0];
  assign ir_legal = (ir_op <= OP_STOREI);
  assign accept   = instr_valid && (state == S_IDLE);

  // Sequencer state, instruction register, wait counter, sticky error and retire count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ir       <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
      retired  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            ir       <= instr;
            err      <= 1'b0;
            wait_cnt <= '0;
            case (instr[31:29])
              OP_LOAD:             state <= S_MEM_RD;
              OP_STORE, OP_STOREI: state <= S_MEM_WR;
              default:             state <= S_EXEC;
            endcase
          end
        end
        S_EXEC: begin
          if (ir_legal) begin
            retired <= retired + CNT_W'(1);
          end else begin
            err <= 1'b1;
          end
          state <= S_IDLE;
        end
        S_MEM_RD, S_MEM_WR: begin
          // An ack in the final wait cycle still completes the transfer.
          if (mem_ack) begin
            retired <= retired + CNT_W'(1);
            state   <= S_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Controls decoded from the registered state and IR so an asynchronous reset drops them at once;
  // only the load write-back looks at mem_ack directly.
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    load_enable = 1'b0;
    dest_select = ir_rd;
    A_select    = ir_ra;
    B_select    = ir_rb;
    mb_select   = 1'b0;
    md_select   = 1'b0;
    constant_in = {9'd0, ir_imm};
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        dest_select = 2'd0;
        A_select    = 2'd0;
        B_select    = 2'd0;
        constant_in = 32'd0;
      end
      S_EXEC: begin
        load_enable = (ir_op == OP_ADD) || (ir_op == OP_ADDI);
        mb_select   = (ir_op == OP_ADDI);
      end
      S_MEM_RD: begin
        mem_rd      = 1'b1;
        load_enable = mem_ack;
        md_select   = mem_ack;
      end
      S_MEM_WR: begin
        mem_wr    = 1'b1;
        mb_select = (ir_op == OP_STOREI);
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a transaction-level expectation model,
// a small datapath register-file model driven by the sequencer controls,
// and literal checks for the hand-computed scenarios.
module tb_datapath_sequencer;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 2;

  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_ADDI   = 3'b010;
  localparam logic [2:0] OP_LOAD   = 3'b011;
  localparam logic [2:0] OP_STORE  = 3'b100;
  localparam logic [2:0] OP_STOREI = 3'b101;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic             load_enable;
  logic [1:0]       dest_select;
  logic [1:0]       A_select;
  logic [1:0]       B_select;
  logic             mb_select;
  logic             md_select;
  logic [31:0]      constant_in;
  logic             mem_rd;
  logic             mem_wr;
  logic             mem_ack;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] retired;

  datapath_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .load_enable (load_enable),
    .dest_select (dest_select),
    .A_select    (A_select),
    .B_select    (B_select),
    .mb_select   (mb_select),
    .md_select   (md_select),
    .constant_in (constant_in),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_ack     (mem_ack),
    .busy        (busy),
    .err         (err),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             instr_ready;
    logic             load_enable;
    logic [1:0]       dest_select;
    logic [1:0]       a_select;
    logic [1:0]       b_select;
    logic             mb_select;
    logic             md_select;
    logic [31:0]      constant_in;
    logic             mem_rd;
    logic             mem_wr;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] retired;
  } obs_t;

  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;
  obs_t exp_o;
  obs_t act_o;

  // Architectural model state (transaction level).
  bit model_err     = 1'b0;
  int model_retired = 0;

  // Datapath memory read data and register file, updated from the sequencer's controls.
  logic [31:0] data_in = 32'hDEADBEEF;
  logic [31:0] regs [4];
  int rd_hi = 0;
  int wr_hi = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= 32'd0;
    end else if (load_enable) begin
      regs[dest_select] <= md_select ? data_in
                                     : regs[A_select] + (mb_select ? constant_in : regs[B_select]);
    end
  end

  always @(negedge clk) begin
    if (mem_rd) rd_hi++;
    if (mem_wr) wr_hi++;
  end

  // What the outputs must be: idle, or working on instruction w (with mem_ack this cycle).
  function automatic obs_t model_outs(bit active, logic [31:0] w, bit ack);
    obs_t o;
    logic [2:0] op;
    o = '0;
    o.err     = model_err;
    o.retired = CNT_W'(model_retired);
    if (!active) begin
      o.instr_ready = 1'b1;
      return o;
    end
    op            = w[31:29];
    o.busy        = 1'b1;
    o.dest_select = w[28:27];
    o.a_select    = w[26:25];
    o.b_select    = w[24:23];
    o.constant_in = {9'd0, w[22:0]};
    case (op)
      OP_ADD:  o.load_enable = 1'b1;
      OP_ADDI: begin o.load_enable = 1'b1; o.mb_select = 1'b1; end
      OP_LOAD: begin
        o.mem_rd = 1'b1;
        if (ack) begin o.load_enable = 1'b1; o.md_select = 1'b1; end
      end
      OP_STORE:  o.mem_wr = 1'b1;
      OP_STOREI: begin o.mem_wr = 1'b1; o.mb_select = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      act_o = {instr_ready, load_enable, dest_select, A_select, B_select, mb_select, md_select,
               constant_in, mem_rd, mem_wr, busy, err, retired};
      checks++;
      if (act_o !== exp_o) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act_o, exp_o);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction; k = cycles in the memory state before mem_ack (negative = never).
  task automatic do_instr(input logic [31:0] w, input int k);
    logic [2:0] op;
    bit ack;
    op          = w[31:29];
    instr       = w;
    instr_valid = 1'b1;
    mem_ack     = 1'b0;
    exp_o       = model_outs(1'b0, w, 1'b0);
    step();
    instr_valid = 1'b0;
    instr       = 32'd0;
    model_err   = 1'b0;
    if (op == OP_LOAD || op == OP_STORE || op == OP_STOREI) begin
      for (int i = 0; i < TIMEOUT; i++) begin
        ack     = (i == k);
        mem_ack = ack;
        exp_o   = model_outs(1'b1, w, ack);
        step();
        if (ack) begin
          model_retired = (model_retired + 1) % (1 << CNT_W);
          break;
        end
        if (i == TIMEOUT - 1) model_err = 1'b1;
      end
    end else begin
      exp_o = model_outs(1'b1, w, 1'b0);
      step();
      if (op > OP_STOREI) model_err = 1'b1;
      else model_retired = (model_retired + 1) % (1 << CNT_W);
    end
    mem_ack = 1'b0;
    exp_o   = model_outs(1'b0, w, 1'b0);
  endtask

  task automatic apply_reset();
    cmp_en        = 1'b0;
    reset         = 1'b1;
    model_err     = 1'b0;
    model_retired = 0;
    step();
    step();
    reset  = 1'b0;
    exp_o  = model_outs(1'b0, 32'd0, 1'b0);
    cmp_en = 1'b1;
  endtask

  initial begin
    reset       = 1'b1;
    instr       = 32'd0;
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    #1;
    check("reset_instr_ready", {31'd0, instr_ready}, 32'd1);
    check("reset_busy",        {31'd0, busy},        32'd0);
    check("reset_mem_rd",      {31'd0, mem_rd},      32'd0);
    check("reset_retired",     {30'd0, retired},     32'd0);
    apply_reset();

    // ADDI r1 = r1 + 5
    do_instr(32'h4A000005, 0);
    check("addi_r1", regs[1], 32'd5);
    check("addi_retired", {30'd0, retired}, 32'd1);

    // ADD r2 = r1 + r1
    do_instr(32'h32800000, 0);
    check("add_r2", regs[2], 32'd10);
    check("add_retired", {30'd0, retired}, 32'd2);

    // LOAD r3 = Mem[r2], ack in the fourth memory cycle (last before timeout)
    rd_hi = 0;
    do_instr(32'h7C000000, 3);
    check("load_rd_cycles", rd_hi, 32'd4);
    check("load_r3", regs[3], 32'hDEADBEEF);
    check("load_retired", {30'd0, retired}, 32'd3);

    // STOREI Mem[r2] = 7, never acknowledged
    wr_hi = 0;
    do_instr(32'hA4000007, -1);
    check("storei_wr_cycles", wr_hi, 32'd4);
    check("storei_err", {31'd0, err}, 32'd1);
    check("storei_retired", {30'd0, retired}, 32'd3);

    // Stray acks while idle are ignored; next NOP clears err and wraps the counter 3 -> 0
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    do_instr(32'h00000000, 0);
    check("nop_err_cleared", {31'd0, err}, 32'd0);
    check("nop_retired_wrap", {30'd0, retired}, 32'd0);

    // STORE Mem[r2] = r1 with immediate ack, then ADDI with maximum immediate
    do_instr(32'h84800000, 0);
    do_instr(32'h4A7FFFFF, 0);
    check("addi_max_r1", regs[1], 32'd5 + 32'h007FFFFF);

    // Illegal opcode 111
    do_instr(32'hE0000000, 0);
    check("illegal_err", {31'd0, err}, 32'd1);
    check("illegal_retired", {30'd0, retired}, 32'd2);

    // Reset asserted in the middle of a LOAD
    instr       = 32'h7C000000;
    instr_valid = 1'b1;
    exp_o       = model_outs(1'b0, instr, 1'b0);
    step();
    instr_valid = 1'b0;
    model_err   = 1'b0;
    exp_o       = model_outs(1'b1, 32'h7C000000, 1'b0);
    step();
    #2;
    model_err     = 1'b0;
    model_retired = 0;
    exp_o         = model_outs(1'b0, 32'd0, 1'b0);
    reset         = 1'b1;
    #1;
    check("midrst_mem_rd",      {31'd0, mem_rd},      32'd0);
    check("midrst_busy",        {31'd0, busy},        32'd0);
    check("midrst_instr_ready", {31'd0, instr_ready}, 32'd1);
    check("midrst_a_select",    {30'd0, A_select},    32'd0);
    check("midrst_retired",     {30'd0, retired},     32'd0);
    step();
    reset = 1'b0;

    // Counter wrap: five NOPs from reset on a 2-bit counter
    apply_reset();
    for (int n = 0; n < 5; n++) do_instr(32'h00000000, 0);
    check("wrap_retired", {30'd0, retired}, 32'd1);

    step();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
